// File: rtl/cache_arbiter.sv
// Two-client arbiter between the split L1 caches and the single physical-memory port.
// One transaction at a time: the winning command is registered onto pmem, the response is routed back.
module cache_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_pmem_read,
  input  logic [15:0]  i_pmem_address,
  output logic [127:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [15:0]  d_pmem_address,
  input  logic [127:0] d_pmem_wdata,
  output logic [127:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           pmem_read_q, pmem_read_d;
  logic           pmem_write_q, pmem_write_d;
  logic [15:0]    pmem_address_q, pmem_address_d;
  logic [127:0]   pmem_wdata_q, pmem_wdata_d;

  logic           i_req_s;
  logic           d_req_s;
  logic           grant_d_s;

  assign i_req_s = i_pmem_read;
  assign d_req_s = d_pmem_read | d_pmem_write;

  // On a tie D wins, unless round-robin is enabled and D held the previous grant.
  assign grant_d_s = d_req_s & (~i_req_s | ~FAIR | (last_grant_q == GRANT_I));

  // Next-state and command logic; the command is only loaded in IDLE and cleared on the response.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;

    case (state_q)
      IDLE: begin
        if (grant_d_s) begin
          state_d        = SERVE_D;
          last_grant_d   = GRANT_D;
          pmem_address_d = d_pmem_address;
          pmem_wdata_d   = d_pmem_wdata;
          // A simultaneous read stays pending behind the write-back.
          pmem_write_d   = d_pmem_write;
          pmem_read_d    = ~d_pmem_write;
        end else if (i_req_s) begin
          state_d        = SERVE_I;
          last_grant_d   = GRANT_I;
          pmem_address_d = i_pmem_address;
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
        end else begin
          state_d        = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d      = DONE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end else begin
          state_d      = state_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  // State and registered pmem command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_I;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= 16'h0000;
      pmem_wdata_q   <= 128'd0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  assign i_pmem_resp  = pmem_resp & (state_q == SERVE_I);
  assign d_pmem_resp  = pmem_resp & (state_q == SERVE_D);
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: instance 0 is round-robin, instance 1 is fixed D priority.
// A latency-programmable memory model answers each command; a scoreboard checks commands and responses.
module tb_cache_arbiter;

  typedef struct {
    int           inst;
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wd;
    logic         chk_wd;
  } cmd_t;

  typedef struct {
    int           inst;
    logic         is_d;
    logic [15:0]  addr;
  } rsp_t;

  typedef struct {
    logic         is_d;
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wd;
    int           lat;
    logic         exp_rd;
    logic         exp_wr;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_rd [2];
  logic         d_rd [2];
  logic         d_wr [2];
  logic [15:0]  i_addr [2];
  logic [15:0]  d_addr [2];
  logic [127:0] d_wd [2];
  logic [127:0] i_rdata [2];
  logic [127:0] d_rdata [2];
  logic         i_resp [2];
  logic         d_resp [2];
  logic         pr [2];
  logic         pw [2];
  logic [15:0]  pa [2];
  logic [127:0] pwd [2];
  logic [127:0] prd [2];
  logic         m_resp_q [2];
  logic         stray [2];
  int unsigned  mcnt [2];

  int           tests = 0;
  int           fails = 0;
  int           lat = 5;
  logic         cmd_prev [2];
  logic [15:0]  hold_a [2];
  logic [127:0] hold_w [2];
  cmd_t         exp_cmd_q [$];
  rsp_t         exp_rsp_q [$];
  vec_t         vecs [6];

  function automatic logic [127:0] line_for(input logic [15:0] a);
    if (a == 16'h1230) return {16{8'hA5}};
    return {8{a ^ 16'h5A5A}};
  endfunction

  function automatic logic [15:0] iaddr(input int j);
    return 16'h1000 + 16'(j * 16);
  endfunction

  function automatic logic [15:0] daddr(input int j);
    return 16'h8000 + 16'(j * 16);
  endfunction

  assign prd[0] = line_for(pa[0]);
  assign prd[1] = line_for(pa[1]);

  cache_arbiter #(.FAIR(1'b1)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .i_pmem_read(i_rd[0]), .i_pmem_address(i_addr[0]),
    .i_pmem_rdata(i_rdata[0]), .i_pmem_resp(i_resp[0]),
    .d_pmem_read(d_rd[0]), .d_pmem_write(d_wr[0]), .d_pmem_address(d_addr[0]),
    .d_pmem_wdata(d_wd[0]), .d_pmem_rdata(d_rdata[0]), .d_pmem_resp(d_resp[0]),
    .pmem_read(pr[0]), .pmem_write(pw[0]), .pmem_address(pa[0]), .pmem_wdata(pwd[0]),
    .pmem_rdata(prd[0]), .pmem_resp(m_resp_q[0] | stray[0])
  );

  cache_arbiter #(.FAIR(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_pmem_read(i_rd[1]), .i_pmem_address(i_addr[1]),
    .i_pmem_rdata(i_rdata[1]), .i_pmem_resp(i_resp[1]),
    .d_pmem_read(d_rd[1]), .d_pmem_write(d_wr[1]), .d_pmem_address(d_addr[1]),
    .d_pmem_wdata(d_wd[1]), .d_pmem_rdata(d_rdata[1]), .d_pmem_resp(d_resp[1]),
    .pmem_read(pr[1]), .pmem_write(pw[1]), .pmem_address(pa[1]), .pmem_wdata(pwd[1]),
    .pmem_rdata(prd[1]), .pmem_resp(m_resp_q[1] | stray[1])
  );

  always #5 clk = ~clk;

  // Memory model: answers an outstanding command with a one-cycle resp 'lat' cycles after it appears.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        mcnt[k]     <= 0;
        m_resp_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_resp_q[k] <= 1'b0;
        if ((pr[k] | pw[k]) && !m_resp_q[k]) begin
          if (mcnt[k] + 1 >= lat) begin
            m_resp_q[k] <= 1'b1;
            mcnt[k]     <= 0;
          end else begin
            mcnt[k] <= mcnt[k] + 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and run the scoreboard on both instances.
  task automatic tick();
    cmd_t e;
    rsp_t r;
    logic cmd;
    @(negedge clk);
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) cmd_prev[k] = 1'b0;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      cmd = pr[k] | pw[k];
      if (cmd) check("rdwr_exclusive", pr[k] & pw[k], 1'b0);
      if (cmd && !cmd_prev[k]) begin
        check("cmd_expected", exp_cmd_q.size() != 0, 1'b1);
        if (exp_cmd_q.size() != 0) begin
          e = exp_cmd_q.pop_front();
          check("cmd_inst", k, e.inst);
          check("cmd_addr", pa[k], e.addr);
          check("cmd_rd", pr[k], e.rd);
          check("cmd_wr", pw[k], e.wr);
          if (e.chk_wd) check("cmd_wdata", pwd[k], e.wd);
        end
        hold_a[k] = pa[k];
        hold_w[k] = pwd[k];
      end else if (cmd) begin
        check("hold_addr", pa[k], hold_a[k]);
        check("hold_wdata", pwd[k], hold_w[k]);
      end
      cmd_prev[k] = cmd;
      if (i_resp[k] | d_resp[k]) begin
        check("resp_expected", exp_rsp_q.size() != 0, 1'b1);
        if (exp_rsp_q.size() != 0) begin
          r = exp_rsp_q.pop_front();
          check("resp_inst", k, r.inst);
          check("resp_i", i_resp[k], !r.is_d);
          check("resp_d", d_resp[k], r.is_d);
          check("resp_rdata", r.is_d ? d_rdata[k] : i_rdata[k], line_for(r.addr));
        end
      end
    end
  endtask

  task automatic wait_resp(input int k, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(i_resp[k] | d_resp[k]) && n < 60);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) cmd_prev[k] = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int n;
    lat = v.lat;
    exp_cmd_q.push_back('{k, v.exp_rd, v.exp_wr, v.addr, v.wd, v.is_d});
    exp_rsp_q.push_back('{k, v.is_d, v.addr});
    if (v.is_d) begin
      d_addr[k] = v.addr;
      d_wd[k]   = v.wd;
      d_rd[k]   = v.rd;
      d_wr[k]   = v.wr;
    end else begin
      i_addr[k] = v.addr;
      i_rd[k]   = 1'b1;
    end
    tick();
    check("grant_latency", pr[k] | pw[k], 1'b1);
    wait_resp(k, n);
    check("resp_latency", n, v.lat);
    i_rd[k] = 1'b0;
    d_rd[k] = 1'b0;
    d_wr[k] = 1'b0;
    tick();
    check("done_gap1", pr[k] | pw[k], 1'b0);
    tick();
    check("done_gap2", pr[k] | pw[k], 1'b0);
  endtask

  // Both clients request continuously; the expected grant order comes from a small arbitration model.
  task automatic run_pair(input int k, input int n_i, input int n_d);
    int   ri, rdn, ji, jd, n;
    logic lg, gd, fair;
    fair = (k == 0);
    ri = n_i;
    rdn = n_d;
    lg = 1'b0;
    while (ri > 0 || rdn > 0) begin
      gd = (rdn > 0) && (ri == 0 || !fair || !lg);
      if (gd) begin
        exp_cmd_q.push_back('{k, 1'b1, 1'b0, daddr(n_d - rdn), 128'd0, 1'b0});
        exp_rsp_q.push_back('{k, 1'b1, daddr(n_d - rdn)});
        rdn--;
        lg = 1'b1;
      end else begin
        exp_cmd_q.push_back('{k, 1'b1, 1'b0, iaddr(n_i - ri), 128'd0, 1'b0});
        exp_rsp_q.push_back('{k, 1'b0, iaddr(n_i - ri)});
        ri--;
        lg = 1'b0;
      end
    end
    lat = 2;
    i_addr[k] = iaddr(0);
    d_addr[k] = daddr(0);
    i_rd[k] = (n_i > 0);
    d_rd[k] = (n_d > 0);
    ji = 0;
    jd = 0;
    n = 0;
    while ((ji < n_i || jd < n_d) && n < 200) begin
      tick();
      n++;
      if (i_resp[k]) begin
        ji++;
        if (ji < n_i) i_addr[k] = iaddr(ji);
        else i_rd[k] = 1'b0;
      end
      if (d_resp[k]) begin
        jd++;
        if (jd < n_d) d_addr[k] = daddr(jd);
        else d_rd[k] = 1'b0;
      end
    end
    check("pair_complete", ji + jd, n_i + n_d);
    i_rd[k] = 1'b0;
    d_rd[k] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h1230, 128'd0,         5, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h4560, {16{8'h0F}},    3, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h7890, {16{8'h33}},    1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'hFFF0, 128'd0,         2, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h0000, {16{8'hFF}},    4, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0010, 128'd0,         1, 1'b1, 1'b0};

    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_rd[k] = 1'b0; d_rd[k] = 1'b0; d_wr[k] = 1'b0;
      i_addr[k] = 16'h0000; d_addr[k] = 16'h0000; d_wd[k] = 128'd0;
      stray[k] = 1'b0; cmd_prev[k] = 1'b0;
      hold_a[k] = 16'h0000; hold_w[k] = 128'd0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_pmem_read", pr[k], 1'b0);
      check("reset_pmem_write", pw[k], 1'b0);
      check("reset_i_resp", i_resp[k], 1'b0);
      check("reset_d_resp", d_resp[k], 1'b0);
      check("reset_pmem_address", pa[k], 16'h0000);
      check("reset_pmem_wdata", pwd[k], 128'd0);
    end
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(0, vecs[i]);

    // A memory response while idle must be ignored.
    stray[0] = 1'b1;
    tick();
    stray[0] = 1'b0;
    tick();
    check("stray_no_cmd", pr[0] | pw[0], 1'b0);
    run_vec(0, vecs[3]);

    reset_pulse();
    run_pair(0, 2, 2);
    run_pair(1, 1, 3);
    reset_pulse();
    run_pair(0, 1, 3);

    // Reset in the middle of a D write-back with an I read waiting behind it.
    reset_pulse();
    lat = 30;
    d_addr[0] = 16'h3000;
    d_wd[0] = {16{8'hC3}};
    d_wr[0] = 1'b1;
    exp_cmd_q.push_back('{0, 1'b0, 1'b1, 16'h3000, {16{8'hC3}}, 1'b1});
    tick();
    check("rst_pre_write", pw[0], 1'b1);
    tick();
    i_addr[0] = 16'h5550;
    i_rd[0] = 1'b1;
    tick();
    check("rst_i_waits", pa[0], 16'h3000);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_write", pw[0], 1'b0);
    check("rst_async_read", pr[0], 1'b0);
    check("rst_async_d_resp", d_resp[0], 1'b0);
    check("rst_async_i_resp", i_resp[0], 1'b0);
    check("rst_async_addr", pa[0], 16'h0000);
    d_wr[0] = 1'b0;
    tick();
    reset_n = 1'b1;
    lat = 2;
    exp_cmd_q.push_back('{0, 1'b1, 1'b0, 16'h5550, 128'd0, 1'b0});
    exp_rsp_q.push_back('{0, 1'b0, 16'h5550});
    tick();
    check("rst_grant_i", pr[0], 1'b1);
    wait_resp(0, n);
    check("rst_i_resp_latency", n, 2);
    i_rd[0] = 1'b0;
    tick();
    tick();

    // Simultaneous D read and write-back to the same line: write first, then the read.
    lat = 2;
    d_addr[0] = 16'h2000;
    d_wd[0] = {8{16'hBEEF}};
    d_rd[0] = 1'b1;
    d_wr[0] = 1'b1;
    exp_cmd_q.push_back('{0, 1'b0, 1'b1, 16'h2000, {8{16'hBEEF}}, 1'b1});
    exp_rsp_q.push_back('{0, 1'b1, 16'h2000});
    exp_cmd_q.push_back('{0, 1'b1, 1'b0, 16'h2000, {8{16'hBEEF}}, 1'b1});
    exp_rsp_q.push_back('{0, 1'b1, 16'h2000});
    tick();
    check("combo_write_first", pw[0], 1'b1);
    wait_resp(0, n);
    check("combo_write_latency", n, 2);
    d_wr[0] = 1'b0;
    tick();
    check("combo_gap1", pr[0] | pw[0], 1'b0);
    tick();
    check("combo_gap2", pr[0] | pw[0], 1'b0);
    wait_resp(0, n);
    check("combo_read_latency", n, 3);
    d_rd[0] = 1'b0;
    tick();
    tick();

    check("sb_cmd_drained", exp_cmd_q.size(), 0);
    check("sb_rsp_drained", exp_rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
